// File: rtl/mem_port_arbiter.sv
// Shares one request/response memory port between instruction fetch and load/store,
// round-robin arbitrated, with byte-lane alignment for LSU stores and load extraction.
module mem_port_arbiter #(
  parameter int ISA_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ifu_req_valid,
  output logic                 ifu_req_ready,
  input  logic [ISA_WIDTH-1:0] ifu_addr,
  output logic                 ifu_resp_valid,
  output logic [ISA_WIDTH-1:0] ifu_rdata,
  input  logic                 lsu_req_valid,
  output logic                 lsu_req_ready,
  input  logic [ISA_WIDTH-1:0] lsu_addr,
  input  logic                 lsu_wen,
  input  logic [1:0]           lsu_size,
  input  logic [ISA_WIDTH-1:0] lsu_wdata,
  output logic                 lsu_resp_valid,
  output logic [ISA_WIDTH-1:0] lsu_rdata,
  output logic                 lsu_err,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic [ISA_WIDTH-1:0] mem_addr,
  output logic                 mem_wen,
  output logic [ISA_WIDTH-1:0] mem_wdata,
  output logic [3:0]           mem_wmask,
  input  logic                 mem_resp_valid,
  input  logic [ISA_WIDTH-1:0] mem_rdata,
  output logic                 busy
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

  state_e               state_q;
  logic                 rr_q;     // 1: LSU wins the next tie
  logic                 owner_q;  // 1: current transaction belongs to LSU
  logic [ISA_WIDTH-1:0] addr_q;
  logic [ISA_WIDTH-1:0] wdata_q;
  logic                 wen_q;
  logic [1:0]           size_q;
  logic [1:0]           off_q;
  logic [3:0]           wmask_q;
  logic                 mem_req_valid_q;
  logic                 ifu_resp_valid_q;
  logic                 lsu_resp_valid_q;
  logic                 lsu_err_q;
  logic [ISA_WIDTH-1:0] ifu_rdata_q;
  logic [ISA_WIDTH-1:0] lsu_rdata_q;

  logic                 grant_ifu;
  logic                 grant_lsu;
  logic                 lsu_misaligned;
  logic [1:0]           lsu_off;
  logic [3:0]           lsu_wmask_d;
  logic [ISA_WIDTH-1:0] lsu_wdata_d;
  logic [ISA_WIDTH-1:0] load_shifted;
  logic [ISA_WIDTH-1:0] load_data_d;

  assign lsu_off = lsu_addr[1:0];

  // Grants are suppressed while reset is asserted so nothing is accepted that cycle.
  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (rst && state_q == S_IDLE) begin
      if (ifu_req_valid && (!lsu_req_valid || !rr_q)) begin
        grant_ifu = 1'b1;
      end else if (lsu_req_valid) begin
        grant_lsu = 1'b1;
      end
    end
  end

  always_comb begin
    lsu_misaligned = 1'b0;
    lsu_wmask_d    = 4'b0000;
    lsu_wdata_d    = '0;
    case (lsu_size)
      2'd0: begin
        lsu_wmask_d = 4'b0001 << lsu_off;
        lsu_wdata_d = ISA_WIDTH'(lsu_wdata[7:0]);
      end
      2'd1: begin
        lsu_misaligned = lsu_off[0];
        lsu_wmask_d    = 4'b0011 << lsu_off;
        lsu_wdata_d    = ISA_WIDTH'(lsu_wdata[15:0]);
      end
      2'd2: begin
        lsu_misaligned = |lsu_off;
        lsu_wmask_d    = 4'b1111;
        lsu_wdata_d    = lsu_wdata;
      end
      default: lsu_misaligned = 1'b1;
    endcase
    lsu_wdata_d = lsu_wdata_d << {lsu_off, 3'b000};
    if (!lsu_wen) begin
      lsu_wmask_d = 4'b0000;
      lsu_wdata_d = '0;
    end
  end

  always_comb begin
    load_shifted = mem_rdata >> {off_q, 3'b000};
    case (size_q)
      2'd0:    load_data_d = ISA_WIDTH'(load_shifted[7:0]);
      2'd1:    load_data_d = ISA_WIDTH'(load_shifted[15:0]);
      default: load_data_d = load_shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q          <= S_IDLE;
      rr_q             <= 1'b0;
      owner_q          <= 1'b0;
      addr_q           <= '0;
      wdata_q          <= '0;
      wen_q            <= 1'b0;
      size_q           <= 2'd0;
      off_q            <= 2'd0;
      wmask_q          <= 4'b0000;
      mem_req_valid_q  <= 1'b0;
      ifu_resp_valid_q <= 1'b0;
      lsu_resp_valid_q <= 1'b0;
      lsu_err_q        <= 1'b0;
      ifu_rdata_q      <= '0;
      lsu_rdata_q      <= '0;
    end else begin
      // Response outputs live for exactly the RESP cycle.
      ifu_resp_valid_q <= 1'b0;
      lsu_resp_valid_q <= 1'b0;
      lsu_err_q        <= 1'b0;
      ifu_rdata_q      <= '0;
      lsu_rdata_q      <= '0;
      case (state_q)
        S_IDLE: begin
          if (grant_ifu) begin
            owner_q         <= 1'b0;
            addr_q          <= {ifu_addr[ISA_WIDTH-1:2], 2'b00};
            wen_q           <= 1'b0;
            size_q          <= 2'd2;
            off_q           <= 2'd0;
            wdata_q         <= '0;
            wmask_q         <= 4'b0000;
            rr_q            <= 1'b1;
            mem_req_valid_q <= 1'b1;
            state_q         <= S_REQ;
          end else if (grant_lsu) begin
            owner_q <= 1'b1;
            addr_q  <= {lsu_addr[ISA_WIDTH-1:2], 2'b00};
            wen_q   <= lsu_wen;
            size_q  <= lsu_size;
            off_q   <= lsu_off;
            wdata_q <= lsu_wdata_d;
            wmask_q <= lsu_wmask_d;
            rr_q    <= 1'b0;
            if (lsu_misaligned) begin
              lsu_resp_valid_q <= 1'b1;
              lsu_err_q        <= 1'b1;
              state_q          <= S_RESP;
            end else begin
              mem_req_valid_q <= 1'b1;
              state_q         <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            state_q         <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_resp_valid) begin
            state_q <= S_RESP;
            if (owner_q) begin
              lsu_resp_valid_q <= 1'b1;
              lsu_rdata_q      <= wen_q ? '0 : load_data_d;
            end else begin
              ifu_resp_valid_q <= 1'b1;
              ifu_rdata_q      <= mem_rdata;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ifu_req_ready  = grant_ifu;
  assign lsu_req_ready  = grant_lsu;
  assign ifu_resp_valid = ifu_resp_valid_q;
  assign ifu_rdata      = ifu_rdata_q;
  assign lsu_resp_valid = lsu_resp_valid_q;
  assign lsu_rdata      = lsu_rdata_q;
  assign lsu_err        = lsu_err_q;
  assign mem_req_valid  = mem_req_valid_q;
  assign mem_addr       = addr_q;
  assign mem_wen        = wen_q;
  assign mem_wdata      = wdata_q;
  assign mem_wmask      = wmask_q;
  assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and random transactions against mem_port_arbiter, checked against
// expectations computed from byte-lane arithmetic and a last-winner arbitration model.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_err;
  logic [1:0]  lsu_size;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.ISA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_size(lsu_size), .lsu_wdata(lsu_wdata),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one transaction from an IDLE arbiter through to its response and back
  // to IDLE, playing the memory side with the given stall and response delay.
  task automatic do_txn(input bit is_lsu, input logic [31:0] addr, input bit wen,
                        input logic [1:0] size, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int stall, input int dly,
                        input bit both);
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic [3:0]  e_mask;
    logic [63:0] lw, lmask;
    bit          e_wen, bad;
    int          off, nb, m;
    off    = int'(addr % 32'd4);
    nb     = 1 << size;
    bad    = is_lsu && (size == 2'd3 || (addr % 32'(nb)) != 32'd0);
    e_addr = (addr / 32'd4) * 32'd4;
    e_wen  = is_lsu && wen;
    m      = ((1 << nb) - 1) << off;
    e_mask = e_wen ? m[3:0] : 4'b0000;
    lmask  = (64'd1 << (8 * nb)) - 64'd1;
    lw     = ({32'd0, wdata} & lmask) << (8 * off);
    e_wdata = lw[31:0];
    lw     = ({32'd0, rdata} >> (8 * off)) & lmask;
    e_rdata = !is_lsu ? rdata : (wen ? 32'd0 : lw[31:0]);

    if (is_lsu) begin
      lsu_req_valid = 1'b1; lsu_addr = addr; lsu_wen = wen; lsu_size = size; lsu_wdata = wdata;
      ifu_req_valid = both;
    end else begin
      ifu_req_valid = 1'b1; ifu_addr = addr;
      lsu_req_valid = both;
    end
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    #1;
    chk("ifu_req_ready@accept", ifu_req_ready, !is_lsu);
    chk("lsu_req_ready@accept", lsu_req_ready, is_lsu);
    tick();
    if (!both) begin
      ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    end
    chk("busy@after_accept", busy, 1);
    if (bad) begin
      chk("mem_req_valid@misaligned", mem_req_valid, 0);
      chk("lsu_resp_valid@misaligned", lsu_resp_valid, 1);
      chk("lsu_err@misaligned", lsu_err, 1);
      tick();
      chk("lsu_resp_valid@after_err", lsu_resp_valid, 0);
      chk("mem_req_valid@after_err", mem_req_valid, 0);
      chk("busy@after_err", busy, 0);
      $display("txn lsu addr=%h size=%0d wen=%0d -> misaligned error", addr, size, wen);
      return;
    end
    for (int i = 0; i <= stall; i++) begin
      chk("mem_req_valid@req", mem_req_valid, 1);
      chk("mem_addr@req", mem_addr, e_addr);
      chk("mem_wen@req", mem_wen, e_wen);
      chk("mem_wmask@req", mem_wmask, e_mask);
      if (e_wen) chk("mem_wdata@req", mem_wdata, e_wdata);
      chk("readies@req", {ifu_req_ready, lsu_req_ready}, 0);
      if (i < stall) begin
        mem_resp_valid = 1'b1;     // stray response while not yet accepted
        mem_rdata = $urandom;
      end else begin
        mem_req_ready = 1'b1;
      end
      tick();
      mem_resp_valid = 1'b0;
      mem_req_ready = 1'b0;
    end
    chk("mem_req_valid@wait", mem_req_valid, 0);
    for (int i = 0; i < dly; i++) begin
      chk("resp_valid@wait", {ifu_resp_valid, lsu_resp_valid}, 0);
      tick();
    end
    mem_resp_valid = 1'b1;
    mem_rdata = rdata;
    tick();
    mem_resp_valid = 1'b0;
    mem_rdata = $urandom;
    chk("ifu_resp_valid@resp", ifu_resp_valid, !is_lsu);
    chk("lsu_resp_valid@resp", lsu_resp_valid, is_lsu);
    chk("lsu_err@resp", lsu_err, 0);
    if (is_lsu) chk("lsu_rdata@resp", lsu_rdata, e_rdata);
    else chk("ifu_rdata@resp", ifu_rdata, e_rdata);
    tick();
    chk("busy@done", busy, 0);
    chk("resp_valid@done", {ifu_resp_valid, lsu_resp_valid}, 0);
    $display("txn %s addr=%h size=%0d wen=%0d stall=%0d dly=%0d rdata=%h",
             is_lsu ? "lsu" : "ifu", addr, size, wen, stall, dly, e_rdata);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit prefer_lsu;
    bit is_lsu;
    rst = 1'b0;
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
    lsu_req_valid = 1'b1; lsu_addr = 32'h0; lsu_wen = 1'b0; lsu_size = 2'd2; lsu_wdata = 32'h0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 32'h0;
    tick();
    tick();
    chk("reset ifu_req_ready", ifu_req_ready, 0);
    chk("reset lsu_req_ready", lsu_req_ready, 0);
    chk("reset busy", busy, 0);
    chk("reset mem_req_valid", mem_req_valid, 0);
    chk("reset resp_valid", {ifu_resp_valid, lsu_resp_valid, lsu_err}, 0);
    chk("reset rdata", ifu_rdata | lsu_rdata, 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset mem_wmask", mem_wmask, 0);
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    rst = 1'b1;
    tick();

    // Directed cases
    do_txn(0, 32'h8000_0004, 0, 2'd2, 32'h0, 32'h0010_0073, 0, 0, 0);
    do_txn(1, 32'h8000_0103, 1, 2'd0, 32'h0000_00AB, 32'h0, 0, 0, 0);
    do_txn(1, 32'h8000_0002, 0, 2'd0, 32'h0, 32'h11CC_2233, 0, 0, 0);
    do_txn(1, 32'h8000_0002, 0, 2'd1, 32'h0, 32'h11CC_2233, 0, 1, 0);
    do_txn(1, 32'h8000_0006, 1, 2'd2, 32'hDEAD_BEEF, 32'h0, 0, 0, 0);
    do_txn(1, 32'h8000_0003, 0, 2'd1, 32'h0, 32'h0, 0, 0, 0);
    do_txn(1, 32'h8000_0008, 0, 2'd3, 32'h0, 32'h0, 0, 0, 0);
    do_txn(1, 32'h8000_0002, 1, 2'd1, 32'h0000_BEEF, 32'h0, 2, 2, 0);

    // Contention straight after reset: both held valid, memory stalls 3 cycles
    do_reset();
    ifu_addr = 32'h8000_0040;
    lsu_addr = 32'h8000_0081; lsu_wen = 1'b1; lsu_size = 2'd0; lsu_wdata = 32'h0000_005A;
    prefer_lsu = 1'b0;
    for (int k = 0; k < 4; k++) begin
      is_lsu = prefer_lsu;
      if (is_lsu) do_txn(1, 32'h8000_0081, 1, 2'd0, 32'h0000_005A, 32'h0, 3, 1, 1);
      else do_txn(0, 32'h8000_0040, 0, 2'd2, 32'h0, 32'hCAFE_0000 + 32'(k), 3, 1, 1);
      prefer_lsu = !is_lsu;
    end
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    tick();

    // Reset while waiting for the memory response
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0200;
    #1;
    chk("rstwait ifu_req_ready", ifu_req_ready, 1);
    tick();
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("rstwait in_wait", {busy, mem_req_valid}, 2'b10);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("rstwait busy", busy, 0);
    mem_resp_valid = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_resp_valid = 1'b0;
    chk("rstwait resp_valid", {ifu_resp_valid, lsu_resp_valid}, 0);
    chk("rstwait busy_after", busy, 0);
    tick();
    chk("rstwait resp_valid_later", {ifu_resp_valid, lsu_resp_valid}, 0);
    do_txn(0, 32'h8000_0204, 0, 2'd2, 32'h0, 32'h0BAD_F00D, 0, 0, 0);

    // Random single-requester traffic
    for (int n = 0; n < 40; n++) begin
      do_txn(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)), $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
